fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction fetch controller for the 8-bit Harvard CPU. It owns the program counter, drives the program-memory address and reads the variable-length instruction stream one byte per cycle. It assembles opcode plus up to two operand bytes and hands the complete instruction to the execute stage over a valid/ready handshake. It also applies JMP targets to the program counter.

## Interface
- No parameters; address and data widths are fixed at 8 bits.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pm_addr  out  8  program-memory address; equals the current PC in every cycle
- pm_data  in  8  program-memory read data; combinational, valid in the same cycle as pm_addr
- instr_valid  out  1  assembled instruction available
- instr_ready  in  1  execute stage accepts the instruction
- opcode  out  8  instruction byte 0
- operand1  out  8  byte 1, or 0 if the instruction has no byte 1
- operand2  out  8  byte 2, or 0 if the instruction has no byte 2
- illegal  out  1  opcode is not in the length table; qualified by instr_valid
- pc  out  8  current program counter (debug)

## Operation
- Instruction length table, fixed:
  - 1 byte: 0x00 NOP, 0x12 CLR
  - 2 bytes: 0x01 ADD Rn, 0x02 SUB Rn, 0x07 JMP target
  - 3 bytes: 0x04 MOV reg→addr, 0x05 MOV addr→reg, 0x06 MOV #imm→reg
  - Any other opcode is treated as 1 byte with illegal=1.
- FSM states and transitions:
  - FETCH_OP: capture pm_data into opcode; clear operand1 and operand2; pc+1. Go to ISSUE if length is 1, else to FETCH_OP1.
  - FETCH_OP1: capture pm_data into operand1; pc+1. Go to ISSUE if length is 2, else to FETCH_OP2.
  - FETCH_OP2: capture pm_data into operand2; pc+1. Go to ISSUE.
  - ISSUE: instr_valid=1.
    - Stay in ISSUE while instr_ready=0.
    - On instr_ready=1, go to FETCH_OP. If opcode=0x07, pc<=operand1 instead of keeping the incremented PC.
- PC arithmetic is 8-bit modulo 256: 0xFF+1 wraps to 0x00. Operands of an instruction that straddles 0xFF→0x00 are fetched across the wrap.
- opcode, operand1, operand2 and illegal are registered. They hold stable for the whole ISSUE state, including while the handshake is stalled.
- JMP is issued to the execute stage like any other instruction, so it is visible for tracing. The PC redirect happens only on acceptance.

## Timing
- Reset values: pc=0x00, pm_addr=0x00, state=FETCH_OP, instr_valid=0, opcode=operand1=operand2=0x00, illegal=0.
- Reset has priority over every other event, including mid-fetch and mid-ISSUE. The partial instruction is discarded and the first fetch after reset reads address 0x00.
- Latency from entering FETCH_OP to instr_valid high:
  - 1-byte instruction: 1 cycle
  - 2-byte instruction: 2 cycles
  - 3-byte instruction: 3 cycles
- Acceptance is the cycle where instr_valid=1 and instr_ready=1.
  - instr_valid drops in the following cycle.
  - The next opcode fetch occurs in that same following cycle, at the incremented PC or the jump target.
- Throughput with instr_ready tied high: one instruction per (length+1) cycles.
- instr_ready is ignored outside ISSUE. instr_valid never deasserts without an acceptance, except on reset.
- pm_addr is driven from the PC register only, with no combinational path from instr_ready.

## Test plan
- Reset, then load program 05 07 02 | 06 0C 03 | 06 01 04 | 01 03 | 12 | 02 04 | 00 | 04 01 03 | 07 21 with instr_ready=1. Required response:
  - Issues in order: (05,07,02), (06,0C,03), (06,01,04), (01,03,00), (12,00,00), (02,04,00), (00,00,00), (04,01,03), (07,21,00).
  - First instr_valid occurs 3 cycles after reset release.
  - After the JMP is accepted, pm_addr=0x21.
- Backpressure: hold instr_ready=0 for 5 cycles during the first ISSUE. Required response: instr_valid stays 1, outputs stay (05,07,02), pc stays 0x03, no fetch occurs. When ready rises, the next fetch is at 0x03.
- Wrap: place 06 AA 05 at 0xFE, 0xFF, 0x00 and start from pc=0xFE via JMP FE at address 0. Required response: issues (06,AA,05), then the next fetch is at 0x01.
- Illegal opcode 0x3F at 0x00 followed by 00. Required response: issues (3F,00,00) with illegal=1 after a 1-cycle latency, then NOP with illegal=0.
- Assert rst for one cycle while in FETCH_OP1 of the first instruction. Required response: next cycle pc=0x00 and instr_valid=0, then the program re-fetches from 0x00 with the same issue sequence as the first scenario.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - variable-length instruction fetch controller with valid/ready issue
module fetch_sequencer (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pm_addr,
    input  logic [7:0] pm_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [7:0] opcode,
    output logic [7:0] operand1,
    output logic [7:0] operand2,
    output logic       illegal,
    output logic [7:0] pc
);

    typedef enum logic [1:0] {
        S_FETCH_OP  = 2'd0,
        S_FETCH_OP1 = 2'd1,
        S_FETCH_OP2 = 2'd2,
        S_ISSUE     = 2'd3
    } state_t;

    localparam logic [7:0] OP_JMP = 8'h07;

    state_t     r_state, w_state_next;
    logic [7:0] r_pc, w_pc_next;
    logic [7:0] r_opcode, w_opcode_next;
    logic [7:0] r_op1, w_op1_next;
    logic [7:0] r_op2, w_op2_next;
    logic       r_illegal, w_illegal_next;
    logic [1:0] w_len_new;
    logic [1:0] w_len_cur;
    logic [7:0] w_pc_inc;

    // Instruction length in bytes; unknown opcodes are single-byte.
    function automatic logic [1:0] len_of(input logic [7:0] op);
        case (op)
            8'h00, 8'h12:        len_of = 2'd1;
            8'h01, 8'h02, 8'h07: len_of = 2'd2;
            8'h04, 8'h05, 8'h06: len_of = 2'd3;
            default:             len_of = 2'd1;
        endcase
    endfunction

    function automatic logic is_known(input logic [7:0] op);
        case (op)
            8'h00, 8'h12, 8'h01, 8'h02, 8'h07, 8'h04, 8'h05, 8'h06: is_known = 1'b1;
            default:                                                is_known = 1'b0;
        endcase
    endfunction

    assign w_len_new = len_of(pm_data);
    assign w_len_cur = len_of(r_opcode);
    assign w_pc_inc  = r_pc + 8'd1;

    // Next-state and datapath capture; PC wraps naturally at 8 bits.
    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_opcode_next  = r_opcode;
        w_op1_next     = r_op1;
        w_op2_next     = r_op2;
        w_illegal_next = r_illegal;
        case (r_state)
            S_FETCH_OP: begin
                w_opcode_next  = pm_data;
                w_op1_next     = 8'h00;
                w_op2_next     = 8'h00;
                w_illegal_next = ~is_known(pm_data);
                w_pc_next      = w_pc_inc;
                w_state_next   = (w_len_new == 2'd1) ? S_ISSUE : S_FETCH_OP1;
            end
            S_FETCH_OP1: begin
                w_op1_next   = pm_data;
                w_pc_next    = w_pc_inc;
                w_state_next = (w_len_cur == 2'd2) ? S_ISSUE : S_FETCH_OP2;
            end
            S_FETCH_OP2: begin
                w_op2_next   = pm_data;
                w_pc_next    = w_pc_inc;
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    w_state_next = S_FETCH_OP;
                    if (r_opcode == OP_JMP) begin
                        w_pc_next = r_op1;
                    end
                end
            end
            default: w_state_next = S_FETCH_OP;
        endcase
    end

    // State and datapath registers; reset discards any partial instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH_OP;
            r_pc      <= 8'h00;
            r_opcode  <= 8'h00;
            r_op1     <= 8'h00;
            r_op2     <= 8'h00;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_opcode  <= w_opcode_next;
            r_op1     <= w_op1_next;
            r_op2     <= w_op2_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign pm_addr     = r_pc;
    assign pc          = r_pc;
    assign instr_valid = (r_state == S_ISSUE);
    assign opcode      = r_opcode;
    assign operand1    = r_op1;
    assign operand2    = r_op2;
    assign illegal     = r_illegal;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] pm_addr;
    logic [7:0] pm_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic       illegal;
    logic [7:0] pc;

    logic [7:0] mem [256];
    logic [7:0] m_pc;
    int         total;
    int         bad;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pm_addr     (pm_addr),
        .pm_data     (pm_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand1    (operand1),
        .operand2    (operand2),
        .illegal     (illegal),
        .pc          (pc)
    );

    assign pm_data = mem[pm_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Length table of the instruction set.
    function automatic int model_len(input logic [7:0] op);
        if (op == 8'h00 || op == 8'h12) return 1;
        if (op == 8'h01 || op == 8'h02 || op == 8'h07) return 2;
        if (op == 8'h04 || op == 8'h05 || op == 8'h06) return 3;
        return 1;
    endfunction

    function automatic logic model_illegal(input logic [7:0] op);
        return !(op inside {8'h00, 8'h12, 8'h01, 8'h02, 8'h07, 8'h04, 8'h05, 8'h06});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_pc = 8'h00;
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_addr", pm_addr, 8'h00);
        chk("rst_instr", {opcode, operand1, operand2}, 24'h0);
        chk("rst_illegal", illegal, 1'b0);
    endtask

    // Fetches, issues and accepts one instruction, comparing against the memory-derived expectation.
    task automatic run_instr(input int stalls, output logic [24:0] got);
        logic [7:0] op, o1, o2, a1, a2, start, pc_after;
        logic       ill;
        int         len, cnt;
        start    = m_pc;
        a1       = m_pc + 8'd1;
        a2       = m_pc + 8'd2;
        op       = mem[start];
        len      = model_len(op);
        ill      = model_illegal(op);
        o1       = (len >= 2) ? mem[a1] : 8'h00;
        o2       = (len >= 3) ? mem[a2] : 8'h00;
        pc_after = start + 8'(len);
        chk("fetch_addr", pm_addr, start);
        cnt = 0;
        while (instr_valid !== 1'b1 && cnt < 8) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            cnt++;
        end
        chk("latency", cnt, len);
        got = {illegal, opcode, operand1, operand2};
        chk("instr", got, {ill, op, o1, o2});
        chk("pc_issue", pc, pc_after);
        for (int s = 0; s < stalls; s++) begin
            instr_ready = 1'b0;
            tick();
            chk("stall_valid", instr_valid, 1'b1);
            chk("stall_instr", {illegal, opcode, operand1, operand2}, {ill, op, o1, o2});
            chk("stall_pc", pc, pc_after);
            chk("stall_addr", pm_addr, pc_after);
        end
        instr_ready = 1'b1;
        tick();
        m_pc = (op == 8'h07) ? o1 : pc_after;
        chk("valid_drop", instr_valid, 1'b0);
        chk("next_addr", pm_addr, m_pc);
    endtask

    logic [7:0]  prog1 [20];
    logic [24:0] exp1  [9];
    logic [7:0]  legal_ops [8];
    logic [24:0] got;

    task automatic load_prog1();
        clear_mem();
        for (int i = 0; i < 20; i++) mem[i] = prog1[i];
    endtask

    task automatic run_prog1(input int first_stall);
        for (int i = 0; i < 9; i++) begin
            run_instr((i == 0) ? first_stall : 0, got);
            chk("seq", got, exp1[i]);
        end
        chk("jmp_target", pm_addr, 8'h21);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        instr_ready = 1'b0;
        prog1 = '{8'h05, 8'h07, 8'h02, 8'h06, 8'h0C, 8'h03, 8'h06, 8'h01, 8'h04, 8'h01,
                  8'h03, 8'h12, 8'h02, 8'h04, 8'h00, 8'h04, 8'h01, 8'h03, 8'h07, 8'h21};
        exp1  = '{25'h0050702, 25'h0060C03, 25'h0060104, 25'h0010300, 25'h0120000,
                  25'h0020400, 25'h0000000, 25'h0040103, 25'h0072100};
        legal_ops = '{8'h00, 8'h12, 8'h01, 8'h02, 8'h07, 8'h04, 8'h05, 8'h06};
        clear_mem();

        // Straight-line program with ready high.
        load_prog1();
        do_reset();
        run_prog1(0);

        // Backpressure on the first issue.
        load_prog1();
        do_reset();
        run_prog1(5);

        // Instruction straddling the 0xFF -> 0x00 wrap.
        clear_mem();
        mem[8'h00] = 8'h07;
        mem[8'h01] = 8'hFE;
        mem[8'hFE] = 8'h06;
        mem[8'hFF] = 8'hAA;
        do_reset();
        run_instr(0, got);
        chk("wrap_jmp", pm_addr, 8'hFE);
        mem[8'h00] = 8'h05;
        run_instr(1, got);
        chk("wrap_instr", got, 25'h006AA05);
        chk("wrap_next", pm_addr, 8'h01);

        // Illegal opcode followed by NOP.
        clear_mem();
        mem[8'h00] = 8'h3F;
        do_reset();
        run_instr(0, got);
        chk("illegal_instr", got, 25'h13F0000);
        run_instr(0, got);
        chk("nop_after_illegal", got, 25'h0000000);

        // Reset pulse during the first operand fetch.
        load_prog1();
        do_reset();
        instr_ready = 1'b1;
        tick();
        chk("mid_pc", pc, 8'h01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_pc", pc, 8'h00);
        chk("mid_rst_valid", instr_valid, 1'b0);
        m_pc = 8'h00;
        run_prog1(0);

        // Random programs with random stalls and random ready outside issue.
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) mem[i] = 8'($urandom);
            else                           mem[i] = legal_ops[$urandom_range(0, 7)];
        end
        do_reset();
        for (int n = 0; n < 150; n++) begin
            run_instr(int'($urandom_range(0, 3)), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
